// File: rtl/seq_div_if.sv
// Handshake and result bus between the ALU control sequencer (master) and seq_div (slave).
interface seq_div_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] first;
  logic [WIDTH-1:0] second;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] outWire;
  logic [WIDTH-1:0] remWire;
  logic             errorWire;

  modport master (
    output start, first, second,
    input  busy, done, outWire, remWire, errorWire
  );

  modport slave (
    input  start, first, second,
    output busy, done, outWire, remWire, errorWire
  );
endinterface

// File: rtl/seq_div.sv
// Iterative restoring divider, one quotient bit per clock, start/busy/done handshake.
// Optional macro DIV_SIGNED_EN: two's-complement operands with an extra sign fix-up cycle.
module seq_div #(
  parameter int unsigned WIDTH = 8
) (
  input  logic      clk,
  input  logic      rstN,
  seq_div_if.slave  bus
);
  localparam int unsigned W  = WIDTH;
  localparam int unsigned CW = $clog2(W);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX, ST_DONE} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   dvs_q, dvs_d;
  logic [W-1:0]   out_q, out_d;
  logic [W-1:0]   rout_q, rout_d;
  logic           err_q, err_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [W-1:0]   mag_a_c, mag_b_c;
  logic [W:0]     shifted_c;
  logic           ge_c;
  logic [W-1:0]   diff_c, rem_nx_c, quo_nx_c;

`ifdef DIV_SIGNED_EN
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
  logic qneg_q, qneg_d, rneg_q, rneg_d;
  logic ovf_c;

  // Iterate on magnitudes; signs are re-applied in the fix-up cycle
  assign mag_a_c = bus.first[W-1]  ? (~bus.first  + W'(1)) : bus.first;
  assign mag_b_c = bus.second[W-1] ? (~bus.second + W'(1)) : bus.second;
  assign ovf_c   = (bus.first == MIN_NEG) && (bus.second == '1);
`else
  assign mag_a_c = bus.first;
  assign mag_b_c = bus.second;
`endif

  // One restoring step: the low W bits of the difference are exact whenever it is non-negative
  assign shifted_c = {rem_q, quo_q[W-1]};
  assign ge_c      = shifted_c >= {1'b0, dvs_q};
  assign diff_c    = shifted_c[W-1:0] - dvs_q;
  assign rem_nx_c  = ge_c ? diff_c : shifted_c[W-1:0];
  assign quo_nx_c  = {quo_q[W-2:0], ge_c};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    out_d   = out_q;
    rout_d  = rout_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef DIV_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif

    case (state_q)
      ST_RUN: begin
        rem_d = rem_nx_c;
        quo_d = quo_nx_c;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
`ifdef DIV_SIGNED_EN
          state_d = ST_FIX;
`else
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          out_d   = quo_nx_c;
          rout_d  = rem_nx_c;
          err_d   = 1'b0;
`endif
        end
      end

`ifdef DIV_SIGNED_EN
      ST_FIX: begin
        state_d = ST_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        err_d   = 1'b0;
        out_d   = qneg_q ? (W'(0) - quo_q) : quo_q;
        rout_d  = rneg_q ? (W'(0) - rem_q) : rem_q;
      end
`endif

      // IDLE and DONE both accept a new operation
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        if (bus.start) begin
          cnt_d = '0;
          rem_d = '0;
          quo_d = mag_a_c;
          dvs_d = mag_b_c;
`ifdef DIV_SIGNED_EN
          qneg_d = bus.first[W-1] ^ bus.second[W-1];
          rneg_d = bus.first[W-1];
`endif
          if (bus.second == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            out_d   = '1;
            rout_d  = bus.first;
            err_d   = 1'b1;
`ifdef DIV_SIGNED_EN
          end else if (ovf_c) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            out_d   = MIN_NEG;
            rout_d  = '0;
            err_d   = 1'b1;
`endif
          end else begin
            state_d = ST_RUN;
            busy_d  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      out_q   <= '0;
      rout_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      out_q   <= out_d;
      rout_q  <= rout_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef DIV_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.outWire   = out_q;
  assign bus.remWire   = rout_q;
  assign bus.errorWire = err_q;
endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: directed cases plus random operands against an arithmetic model.
module tb_seq_div;
  localparam int unsigned W = 8;

  logic clk;
  logic rstN;
  int   n_checks = 0;
  int   n_fail   = 0;

  seq_div_if #(.WIDTH(W)) bus ();

  seq_div #(.WIDTH(W)) u_dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division; lat is edges after the accepting edge until done (-1 = unchecked)
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic e, output int lat);
`ifdef DIV_SIGNED_EN
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (b == '0) begin
      q = '1; r = a; e = 1'b1; lat = 0;
    end else if (sa == -(2 ** (W - 1)) && sb == -1) begin
      q = W'(sa); r = '0; e = 1'b1; lat = -1;
    end else begin
      q = W'(sa / sb); r = W'(sa % sb); e = 1'b0; lat = W + 1;
    end
`else
    if (b == '0) begin
      q = '1; r = a; e = 1'b1; lat = 0;
    end else begin
      q = a / b; r = a % b; e = 1'b0; lat = W;
    end
`endif
  endfunction

  // Present one start pulse; returns #1 after the accepting edge
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start  = 1'b1;
    bus.first  = a;
    bus.second = b;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.first  = W'($urandom);
    bus.second = W'($urandom);
  endtask

  // Wait (bounded) for done, then check latency, handshake and results; k0 = edges already elapsed
  task automatic wait_check(input logic [W-1:0] a, input logic [W-1:0] b,
                            input string tag, input int k0);
    logic [W-1:0] eq, er;
    logic         ee;
    int           elat, k;
    bit           seen, busy_bad;
    model(a, b, eq, er, ee, elat);
    k = k0; seen = 1'b0; busy_bad = 1'b0;
    while (!seen && k <= 2 * W + 4) begin
      if (bus.done === 1'b1) seen = 1'b1;
      else begin
        if (bus.busy !== 1'b1) busy_bad = 1'b1;
        @(posedge clk); #1;
        k++;
      end
    end
    check({tag, " done seen"}, 32'(seen), 32'd1);
    if (elat >= 0) check({tag, " latency"}, 32'(k), 32'(elat));
    if (elat > 0)  check({tag, " busy while running"}, 32'(busy_bad), 32'd0);
    check({tag, " busy at done"}, 32'(bus.busy), 32'd0);
    check({tag, " quotient"}, 32'(bus.outWire), 32'(eq));
    check({tag, " remainder"}, 32'(bus.remWire), 32'(er));
    check({tag, " error"}, 32'(bus.errorWire), 32'(ee));
    @(posedge clk); #1;
    check({tag, " done one cycle"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rstN       = 1'b0;
    bus.start  = 1'b0;
    bus.first  = '0;
    bus.second = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset out", 32'(bus.outWire), 32'd0);
    check("reset rem", 32'(bus.remWire), 32'd0);
    check("reset err", 32'(bus.errorWire), 32'd0);
    rstN = 1'b1;
    @(posedge clk); #1;

    start_op(8'd100, 8'd7);
    wait_check(8'd100, 8'd7, "100/7", 0);
    repeat (3) @(posedge clk);
    #1;
    check("hold out", 32'(bus.outWire), 32'd14);
    check("hold rem", 32'(bus.remWire), 32'd2);
    check("hold done low", 32'(bus.done), 32'd0);

    start_op(8'd5, 8'd0);
    wait_check(8'd5, 8'd0, "5/0", 0);
    check("5/0 busy after", 32'(bus.busy), 32'd0);

    // Second start while busy must be ignored
    start_op(8'd200, 8'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.first = 8'd9; bus.second = 8'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_check(8'd200, 8'd3, "ignored start", 3);

    // Start held through done: re-accepted in the done cycle
    bus.start = 1'b1; bus.first = 8'd255; bus.second = 8'd16;
    @(posedge clk); #1;
    wait_check(8'd255, 8'd16, "b2b first", 0);
    bus.start = 1'b0;
    wait_check(8'd255, 8'd16, "b2b second", 0);

    // Asynchronous reset in the middle of an operation
    start_op(8'd123, 8'd5);
    repeat (3) @(posedge clk);
    #2;
    rstN = 1'b0;
    #1;
    check("midrst busy", 32'(bus.busy), 32'd0);
    check("midrst done", 32'(bus.done), 32'd0);
    check("midrst out", 32'(bus.outWire), 32'd0);
    check("midrst rem", 32'(bus.remWire), 32'd0);
    check("midrst err", 32'(bus.errorWire), 32'd0);
    @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;
    check("midrst idle", 32'(bus.busy), 32'd0);
    start_op(8'd50, 8'd5);
    wait_check(8'd50, 8'd5, "50/5", 0);

`ifdef DIV_SIGNED_EN
    start_op(8'h9C, 8'd7);
    wait_check(8'h9C, 8'd7, "-100/7", 0);
    start_op(8'h80, 8'hFF);
    wait_check(8'h80, 8'hFF, "-128/-1", 0);
`endif

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      start_op(ra, rb);
      wait_check(ra, rb, "random", 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
